// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage floating-point multiplier (decode, multiply, normalise/pack)
// with valid/ready flow control. Define FPMUL_RNE_EN for round-to-nearest-even; default truncates.
module fp_mul_pipe #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int MAN_KEEP = 13,
  parameter int TAG_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_KEEP + 1;
  localparam int PW = 2 * SW;
  localparam int FW = PW - 1;
  localparam int XW = EXP_W + 2;

  localparam logic        [XW-1:0]    BIAS     = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0]    EXP_MAX  = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0]    EXP_ZERO = '0;
  localparam logic        [MAN_W-1:0] QNAN_MAN = MAN_W'(1) << (MAN_W - 1);

  typedef struct packed {
    logic             sign;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
    logic [XW-1:0]    exp_sum;
    logic [TAG_W-1:0] tag;
  } meta_t;

  logic adv;
  logic v1_q, v2_q, v3_q;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  meta_t            meta1_d, meta1_q, meta2_q;
  logic [SW-1:0]    sig_a_d, sig_b_d, sig_a_q, sig_b_q;
  logic [PW-1:0]    prod_d, prod_q;

  logic                    msb;
  logic [FW-1:0]           frac;
  logic [FW+MAN_W:0]       ext;
  logic [MAN_W-1:0]        man_t, man_f;
  logic signed [XW-1:0]    exp_n, exp_f;
  logic [DW-1:0]           out_data_d, out_data_q;
  logic [TAG_W-1:0]        out_tag_d, out_tag_q;
`ifdef FPMUL_RNE_EN
  logic                    guard, sticky, round_up;
  logic [MAN_W:0]          man_r;
`endif

  // The whole pipeline moves as one; in_ready is the same term, unregistered.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  // S1 decode: classify operands and form sign, exponent sum and kept significands.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier results.
    {sign_a, exp_a, man_a} = in_a;
    {sign_b, exp_b, man_b} = in_b;
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (&exp_a) & ~(|man_a);
    inf_b  = (&exp_b) & ~(|man_b);
    nan_a  = (&exp_a) & (|man_a);
    nan_b  = (&exp_b) & (|man_b);

    meta1_d.sign    = sign_a ^ sign_b;
    meta1_d.is_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    meta1_d.is_inf  = inf_a | inf_b;
    meta1_d.is_zero = zero_a | zero_b;
    meta1_d.exp_sum = {2'b00, exp_a} + {2'b00, exp_b};
    meta1_d.tag     = in_tag;

    sig_a_d = {1'b1, man_a[MAN_W-1 -: MAN_KEEP]};
    sig_b_d = {1'b1, man_b[MAN_W-1 -: MAN_KEEP]};
  end

  // S2 multiply.
  assign prod_d = PW'(sig_a_q) * PW'(sig_b_q);

  // S3 normalise, round and pack with special-case priority.
  always_comb begin
    msb   = prod_q[PW-1];
    frac  = msb ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    ext   = {frac, {(MAN_W + 1){1'b0}}};
    man_t = MAN_W'(ext >> (FW + 1));
    exp_n = meta2_q.exp_sum - BIAS + XW'(msb);
`ifdef FPMUL_RNE_EN
    guard    = ext[FW];
    sticky   = |ext[FW-1:0];
    round_up = guard & (sticky | man_t[0]);
    man_r    = {1'b0, man_t} + (MAN_W + 1)'(round_up);
    // A carry-out leaves the fraction at zero and bumps the exponent.
    man_f    = man_r[MAN_W-1:0];
    exp_f    = exp_n + XW'(man_r[MAN_W]);
`else
    man_f = man_t;
    exp_f = exp_n;
`endif
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    out_data_d = {meta2_q.sign, exp_f[EXP_W-1:0], man_f};
    out_tag_d  = meta2_q.tag;
    if (meta2_q.is_nan)
      out_data_d = {1'b0, {EXP_W{1'b1}}, QNAN_MAN};
    else if (meta2_q.is_inf || exp_f >= EXP_MAX)
      out_data_d = {meta2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (meta2_q.is_zero || exp_f <= EXP_ZERO)
      out_data_d = {meta2_q.sign, {(DW - 1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        out_data_q <= out_data_d;
        out_tag_q  <= out_tag_d;
      end
    end
  end

  // NOTE: inner datapath registers have no reset; the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      meta1_q <= meta1_d;
      sig_a_q <= sig_a_d;
      sig_b_q <= sig_b_d;
    end
    if (adv && v1_q) begin
      meta2_q <= meta1_q;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier for the radix-4 FFT butterfly datapath. Accepts one operand pair per cycle under a valid/ready handshake, multiplies a configurable number of mantissa MSBs, and normalises and packs the result three cycles later. It adds special-value handling (zero, infinity, NaN, overflow, underflow) and an optional tag carried alongside each product. It replaces the combinational single-precision multiplier in twiddle-multiply paths.

## Interface
- EXP_W, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, default 23: stored mantissa field width.
- MAN_KEEP, default 13: mantissa MSBs fed to the multiplier (1 ≤ MAN_KEEP ≤ MAN_W); lower bits are ignored.
- TAG_W, default 4: sideband tag width (e.g. FFT point index), passed through unchanged.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- in_a, in_b  input  1+EXP_W+MAN_W  operands {sign, exp, man}.
- in_tag  input  TAG_W  tag for this pair.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  1+EXP_W+MAN_W  product.
- out_tag  output  TAG_W  tag of this product.

## Operation
- Stage S1 (decode): register the sign XOR, the biased exponent sum (EXP_W+2 bits, signed) and the significands {1, man[MAN_W-1 -: MAN_KEEP]}. Classify each operand: zero/denormal (exp==0, flushed to zero), inf (exp all ones, man==0), NaN (exp all ones, man≠0).
- Stage S2 (multiply): form the unsigned product of two (MAN_KEEP+1)-bit significands, giving a 2·MAN_KEEP+2-bit result. Forward the class flags, sign, exponent and tag.
- Stage S3 (normalise/pack):
  - If product MSB=1: exponent = sum − bias + 1, and the fraction is taken from the bits below the MSB.
  - Otherwise: exponent = sum − bias, and the fraction is taken from the bits below MSB−1.
  - The fraction is left-aligned into MAN_W bits and zero-filled.
- Rounding: truncation (toward zero) unless FPMUL_RNE_EN is defined.
- Special-case priority, highest first:
  1. Any NaN, or inf × zero → canonical NaN {0, all-ones exp, 1 followed by zeros}.
  2. Any inf → signed inf.
  3. Any zero → signed zero.
  4. Final exponent ≥ all-ones → signed inf (overflow).
  5. Final exponent ≤ 0 → signed zero (underflow, no denormals).
- Sign rule: the sign is always a XOR b, except for NaN (sign 0).

## Timing
- Latency: exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, given no stall.
- Throughput: 1 result per cycle.
- Global stall: the pipeline advances when out_ready | ~out_valid. in_ready equals the same term and is combinational, with no register.
- Bubbles are not squeezed out. A stall freezes all three stages.
- Hold rule: out_data and out_tag stay stable while out_valid & ~out_ready.
- Reset:
  - All stage valid bits clear, out_valid=0, out_data=0, out_tag=0.
  - Reset mid-operation discards every in-flight pair.
  - in_ready=1 in the first cycle after reset.
- Simultaneous accept-in and accept-out in the same cycle is a normal pipeline shift; no result is lost or duplicated.

## Configuration
- FPMUL_RNE_EN defined:
  - S3 rounds to nearest, ties to even, using the guard bit and the OR of the discarded bits.
  - A mantissa carry-out renormalises: exponent +1, fraction 0.
  - Overflow is checked after rounding.
  - Latency is unchanged.
- FPMUL_RNE_EN undefined: truncation; the rounding logic is absent.

## Test plan
- Basic products, MAN_KEEP=13, back-to-back, out_ready=1:
  - 0x40000000×0x40400000 → 0x40C00000.
  - 0x3FC00000×0x3FC00000 → 0x40100000.
  - 0xC0000000×0x3F000000 → 0xBF800000.
  - Each result arrives exactly 3 cycles after its input, with tags 1, 2, 3 in order.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000.
  - 0x7F000000×0x7F000000 → 0x7F800000.
  - 0x00800000×0x00800000 → 0x00000000.
  - 0x80000000×0x3F800000 → 0x80000000.
- Rounding, MAN_KEEP=23, 0x3FC00001×0x3FC00001:
  - FPMUL_RNE_EN undefined → 0x40100001.
  - FPMUL_RNE_EN defined → 0x40100002.
- Backpressure:
  - Stimulus: stream 8 pairs and drop out_ready for 4 cycles mid-stream.
  - Check that in_ready drops in the same cycles, out_data is held, and all 8 results appear in order with none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 pairs in flight.
  - Check out_valid=0 in the next cycle and no stale result ever appears.
  - Check that the next accepted pair emerges 3 cycles after acceptance.
